// File: rtl/door_alarm_ctrl_pkg.sv
// Shared types and constants for the door alarm controller and its keypad checker.
// State encodings are visible on fsm_state, so they are fixed explicitly.
package door_alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_ARMING   = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } alarm_state_t;

    localparam int DIGIT_W     = 4;
    localparam int CODE_DIGITS = 4;
    localparam int CODE_W      = DIGIT_W * CODE_DIGITS;
    localparam int TIMER_W     = 16;
    localparam int FAIL_W      = 4;

    localparam int              DEF_EXIT_CYC  = 16;
    localparam int              DEF_ENTRY_CYC = 16;
    localparam int              DEF_SIREN_CYC = 32;
    localparam logic [CODE_W-1:0] DEF_CODE    = 16'h1234;
    localparam int              DEF_MAX_FAIL  = 3;
    localparam int              DEF_LOCK_CYC  = 64;

endpackage

// File: rtl/door_alarm_ctrl_code_checker.sv
// Keypad code checker: collects decimal digits, compares on the last one,
// counts wrong codes and runs the keypad lockout timer.
module code_checker
    import door_alarm_pkg::*;
#(
    parameter logic [CODE_W-1:0] CODE     = DEF_CODE,
    parameter int                MAX_FAIL = DEF_MAX_FAIL,
    parameter int                LOCK_CYC = DEF_LOCK_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_enable,
    input  logic [DIGIT_W-1:0] i_key,
    input  logic               i_key_valid,
    output logic               o_code_ok,
    output logic               o_code_bad,
    output logic               o_locked
);

    logic [CODE_W-1:0]  r_buf;
    logic [1:0]         r_count;
    logic [FAIL_W-1:0]  r_fails;
    logic [TIMER_W-1:0] r_lockCnt;
    logic               r_locked;

    logic               w_accept;
    logic               w_last;
    logic [CODE_W-1:0]  w_candidate;
    logic [FAIL_W-1:0]  w_failsNext;

    // Non-decimal digits are dropped without touching the count.
    assign w_accept    = i_enable && i_key_valid && !r_locked && (i_key <= 4'd9);
    assign w_last      = w_accept && (r_count == 2'(CODE_DIGITS - 1));
    assign w_candidate = {r_buf[CODE_W-DIGIT_W-1:0], i_key};
    assign w_failsNext = (r_fails >= FAIL_W'(MAX_FAIL)) ? r_fails : r_fails + FAIL_W'(1);

    assign o_code_ok  = w_last && (w_candidate == CODE);
    assign o_code_bad = w_last && (w_candidate != CODE);
    assign o_locked   = r_locked;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf     <= '0;
            r_count   <= '0;
            r_fails   <= '0;
            r_lockCnt <= '0;
            r_locked  <= 1'b0;
        end else begin
            if (!i_enable) begin
                r_buf   <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_buf   <= '0;
                    r_count <= '0;
                end else begin
                    r_buf   <= w_candidate;
                    r_count <= r_count + 2'd1;
                end
            end

            // Wrong codes cannot arrive while locked, so lock and fail updates never collide.
            if (r_locked) begin
                if (r_lockCnt == TIMER_W'(1)) begin
                    r_locked  <= 1'b0;
                    r_lockCnt <= '0;
                    r_fails   <= '0;
                end else begin
                    r_lockCnt <= r_lockCnt - TIMER_W'(1);
                end
            end else if (o_code_bad) begin
                r_fails <= w_failsNext;
                if (w_failsNext >= FAIL_W'(MAX_FAIL)) begin
                    r_locked  <= 1'b1;
                    r_lockCnt <= TIMER_W'(LOCK_CYC);
                end
            end else if (o_code_ok) begin
                r_fails <= '0;
            end
        end
    end

endmodule

// File: rtl/door_alarm_ctrl.sv
// Door-sequence alarm supervisor: arming, exit/entry delays, siren timing, keypad disarm.
// Optional macro DOOR_ALARM_CTRL_TAMPER_EN makes the tamper contact force ALARM.
module door_alarm_ctrl
    import door_alarm_pkg::*;
#(
    parameter int                BITS      = 2,
    parameter int                EXIT_CYC  = DEF_EXIT_CYC,
    parameter int                ENTRY_CYC = DEF_ENTRY_CYC,
    parameter int                SIREN_CYC = DEF_SIREN_CYC,
    parameter logic [CODE_W-1:0] CODE      = DEF_CODE,
    parameter int                MAX_FAIL  = DEF_MAX_FAIL,
    parameter int                LOCK_CYC  = DEF_LOCK_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BITS-1:0]    in_port,
    input  logic               arm,
    input  logic [DIGIT_W-1:0] key,
    input  logic               key_valid,
    input  logic               tamper,
    output logic               armed,
    output logic               siren,
    output logic               entry_warn,
    output logic               locked,
    output logic [2:0]         fsm_state
);

    alarm_state_t       r_state;
    alarm_state_t       w_nextState;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_nextTimer;
    logic               w_expire;
    logic               w_codeOk;
    logic               w_codeBad;
    logic               w_locked;

    code_checker #(
        .CODE     (CODE),
        .MAX_FAIL (MAX_FAIL),
        .LOCK_CYC (LOCK_CYC)
    ) u_code_checker (
        .clk         (clk),
        .reset       (reset),
        .i_enable    (r_state != ST_DISARMED),
        .i_key       (key),
        .i_key_valid (key_valid),
        .o_code_ok   (w_codeOk),
        .o_code_bad  (w_codeBad),
        .o_locked    (w_locked)
    );

`ifndef DOOR_ALARM_CTRL_TAMPER_EN
    logic w_unusedTamper;
    assign w_unusedTamper = tamper ^ w_codeBad;
`else
    logic w_unusedCodeBad;
    assign w_unusedCodeBad = w_codeBad;
`endif

    assign w_expire = (r_timer == TIMER_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_DISARMED;
            r_timer <= '0;
        end else begin
            r_state <= w_nextState;
            r_timer <= w_nextTimer;
        end
    end

    // A correct code outranks door events and expiry; expiry outranks door events.
    always_comb begin
        w_nextState = r_state;
        w_nextTimer = r_timer;
        case (r_state)
            ST_DISARMED: begin
                w_nextTimer = '0;
                if (arm) begin
                    w_nextState = ST_ARMING;
                    w_nextTimer = TIMER_W'(EXIT_CYC);
                end
            end
            ST_ARMING: begin
                if (w_codeOk) begin
                    w_nextState = ST_DISARMED;
                    w_nextTimer = '0;
                end else if (w_expire) begin
                    w_nextState = ST_ARMED;
                    w_nextTimer = '0;
                end else begin
                    w_nextTimer = r_timer - TIMER_W'(1);
                end
            end
            ST_ARMED: begin
                w_nextTimer = '0;
                if (w_codeOk) begin
                    w_nextState = ST_DISARMED;
                end else if (in_port != '0) begin
                    w_nextState = ST_ENTRY;
                    w_nextTimer = TIMER_W'(ENTRY_CYC);
                end
            end
            ST_ENTRY: begin
                if (w_codeOk) begin
                    w_nextState = ST_DISARMED;
                    w_nextTimer = '0;
                end else if (w_expire) begin
                    w_nextState = ST_ALARM;
                    w_nextTimer = TIMER_W'(SIREN_CYC);
                end else begin
                    w_nextTimer = r_timer - TIMER_W'(1);
                end
            end
            ST_ALARM: begin
                if (w_codeOk) begin
                    w_nextState = ST_DISARMED;
                    w_nextTimer = '0;
                end else if (w_expire) begin
                    w_nextState = ST_ARMED;
                    w_nextTimer = '0;
                end else begin
                    w_nextTimer = r_timer - TIMER_W'(1);
                end
            end
            default: begin
                w_nextState = ST_DISARMED;
                w_nextTimer = '0;
            end
        endcase
`ifdef DOOR_ALARM_CTRL_TAMPER_EN
        if (tamper) begin
            w_nextState = ST_ALARM;
            w_nextTimer = TIMER_W'(SIREN_CYC);
        end
`endif
    end

    assign armed      = (r_state == ST_ARMED) || (r_state == ST_ENTRY) || (r_state == ST_ALARM);
    assign siren      = (r_state == ST_ALARM);
    assign entry_warn = (r_state == ST_ARMING) || (r_state == ST_ENTRY);
    assign locked     = w_locked;
    assign fsm_state  = r_state;

endmodule

// File: tb/tb_door_alarm_ctrl.sv
// Self-checking bench for door_alarm_ctrl: cycle model compared every cycle plus directed literal checks.
// Honours DOOR_ALARM_CTRL_TAMPER_EN for the tamper scenario.
module tb_door_alarm_ctrl;

    localparam int BITS      = 2;
    localparam int EXIT_CYC  = 4;
    localparam int ENTRY_CYC = 3;
    localparam int SIREN_CYC = 5;
    localparam int CODE      = 'h1234;
    localparam int MAX_FAIL  = 3;
    localparam int LOCK_CYC  = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [BITS-1:0] in_port = '0;
    logic            arm = 1'b0;
    logic [3:0]      key = '0;
    logic            key_valid = 1'b0;
    logic            tamper = 1'b0;
    logic            armed;
    logic            siren;
    logic            entry_warn;
    logic            locked;
    logic [2:0]      fsm_state;

    int  nChecks = 0;
    int  nFail = 0;
    bit  checkEn = 1'b0;

    always #5 clk = ~clk;

    door_alarm_ctrl #(
        .BITS      (BITS),
        .EXIT_CYC  (EXIT_CYC),
        .ENTRY_CYC (ENTRY_CYC),
        .SIREN_CYC (SIREN_CYC),
        .CODE      (16'h1234),
        .MAX_FAIL  (MAX_FAIL),
        .LOCK_CYC  (LOCK_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .arm        (arm),
        .key        (key),
        .key_valid  (key_valid),
        .tamper     (tamper),
        .armed      (armed),
        .siren      (siren),
        .entry_warn (entry_warn),
        .locked     (locked),
        .fsm_state  (fsm_state)
    );

    // Reference model: phase number, cycles spent in phase, digit queue, lockout cycles remaining.
    int mState = 0;
    int mAge = 0;
    int mFails = 0;
    int mLock = 0;
    int mDigs[$];
    bit mOk;
    bit mBad;
    bit mTimeUp;
    int mCode;
    int mNext;
    bit mTamper;

    function automatic int durOf(input int s);
        case (s)
            1:       return EXIT_CYC;
            3:       return ENTRY_CYC;
            4:       return SIREN_CYC;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mState = 0;
            mAge = 0;
            mFails = 0;
            mLock = 0;
            mDigs.delete();
        end else begin
            mOk = 1'b0;
            mBad = 1'b0;
`ifdef DOOR_ALARM_CTRL_TAMPER_EN
            mTamper = tamper;
`else
            mTamper = 1'b0;
`endif
            if (mState != 0 && key_valid && mLock == 0 && int'(key) <= 9) begin
                mDigs.push_back(int'(key));
                if (mDigs.size() == 4) begin
                    mCode = mDigs[0] * 4096 + mDigs[1] * 256 + mDigs[2] * 16 + mDigs[3];
                    mOk = (mCode == CODE);
                    mBad = !mOk;
                    mDigs.delete();
                end
            end
            if (mLock > 0) begin
                mLock--;
                if (mLock == 0) mFails = 0;
            end else if (mBad) begin
                if (mFails < MAX_FAIL) mFails++;
                if (mFails >= MAX_FAIL) mLock = LOCK_CYC;
            end
            if (mOk) mFails = 0;

            mTimeUp = (durOf(mState) > 0) && (mAge + 1 >= durOf(mState));
            mNext = mState;
            if (mTamper) mNext = 4;
            else if (mOk) mNext = 0;
            else begin
                case (mState)
                    0: if (arm) mNext = 1;
                    1: if (mTimeUp) mNext = 2;
                    2: if (in_port != 0) mNext = 3;
                    3: if (mTimeUp) mNext = 4;
                    4: if (mTimeUp) mNext = 2;
                    default: mNext = 0;
                endcase
            end
            if (mNext != mState || mTamper) mAge = 0;
            else mAge++;
            mState = mNext;
            if (mState == 0) mDigs.delete();
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model.fsm_state", int'(fsm_state), mState);
            checkOutput("model.armed", int'(armed), int'(mState >= 2));
            checkOutput("model.siren", int'(siren), int'(mState == 4));
            checkOutput("model.entry_warn", int'(entry_warn), int'(mState == 1 || mState == 3));
            checkOutput("model.locked", int'(locked), int'(mLock > 0));
        end
    end

    task automatic applyStimulus(input logic a, input logic [BITS-1:0] door, input logic [3:0] k,
                                 input logic kv, input logic t);
        arm = a;
        in_port = door;
        key = k;
        key_valid = kv;
        tamper = t;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic pressKey(input logic [3:0] k);
        applyStimulus(1'b0, '0, k, 1'b1, 1'b0);
    endtask

    task automatic armToArmed();
        applyStimulus(1'b1, '0, 4'd0, 1'b0, 1'b0);
        idle(EXIT_CYC);
        checkOutput("armed_after_exit", int'(fsm_state), 2);
    endtask

    initial begin
        #1 reset = 1'b1;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("reset.fsm_state", int'(fsm_state), 0);
        checkOutput("reset.armed", int'(armed), 0);
        checkOutput("reset.siren", int'(siren), 0);
        checkOutput("reset.entry_warn", int'(entry_warn), 0);
        checkOutput("reset.locked", int'(locked), 0);
        reset = 1'b0;
        idle(2);

        $display("[TB] arming sequence");
        applyStimulus(1'b1, '0, 4'd0, 1'b0, 1'b0);
        checkOutput("arming.state", int'(fsm_state), 1);
        checkOutput("arming.warn", int'(entry_warn), 1);
        for (int i = 0; i < EXIT_CYC - 1; i++) applyStimulus(1'b0, 2'd1, 4'd0, 1'b0, 1'b0);
        checkOutput("arming.door_ignored", int'(fsm_state), 1);
        idle(1);
        checkOutput("armed.state", int'(fsm_state), 2);
        checkOutput("armed.armed", int'(armed), 1);
        applyStimulus(1'b1, '0, 4'd0, 1'b0, 1'b0);
        checkOutput("armed.arm_ignored", int'(fsm_state), 2);

        $display("[TB] entry delay and siren");
        applyStimulus(1'b0, 2'd2, 4'd0, 1'b0, 1'b0);
        checkOutput("entry.state", int'(fsm_state), 3);
        idle(ENTRY_CYC - 1);
        checkOutput("entry.last_cycle", int'(fsm_state), 3);
        idle(1);
        checkOutput("alarm.siren_on", int'(siren), 1);
        idle(SIREN_CYC - 1);
        checkOutput("alarm.last_cycle", int'(siren), 1);
        idle(1);
        checkOutput("alarm.back_armed", int'(fsm_state), 2);
        checkOutput("alarm.siren_off", int'(siren), 0);
        checkOutput("alarm.still_armed", int'(armed), 1);

        $display("[TB] disarm during entry");
        pressKey(4'd1);
        pressKey(4'd2);
        applyStimulus(1'b0, 2'd1, 4'd3, 1'b1, 1'b0);
        checkOutput("entry_disarm.entry", int'(fsm_state), 3);
        pressKey(4'd4);
        checkOutput("entry_disarm.state", int'(fsm_state), 0);
        checkOutput("entry_disarm.armed", int'(armed), 0);
        checkOutput("entry_disarm.siren", int'(siren), 0);

        $display("[TB] code on expiry cycle");
        armToArmed();
        pressKey(4'd1);
        applyStimulus(1'b0, 2'd3, 4'd2, 1'b1, 1'b0);
        pressKey(4'd3);
        idle(1);
        checkOutput("expiry_tie.pre", int'(fsm_state), 3);
        pressKey(4'd4);
        checkOutput("expiry_tie.state", int'(fsm_state), 0);
        checkOutput("expiry_tie.siren", int'(siren), 0);

        $display("[TB] lockout");
        armToArmed();
        for (int i = 0; i < 4 * MAX_FAIL; i++) begin
            pressKey(4'd0);
            if (i == 4 * MAX_FAIL - 5) checkOutput("lock.not_yet", int'(locked), 0);
        end
        checkOutput("lock.set", int'(locked), 1);
        pressKey(4'd1);
        pressKey(4'd2);
        pressKey(4'd3);
        pressKey(4'd4);
        checkOutput("lock.code_ignored", int'(fsm_state), 2);
        idle(1);
        checkOutput("lock.last_cycle", int'(locked), 1);
        idle(1);
        checkOutput("lock.released", int'(locked), 0);
        pressKey(4'd1);
        pressKey(4'hA);
        pressKey(4'd2);
        pressKey(4'd3);
        checkOutput("lock.bad_digit_skipped", int'(fsm_state), 2);
        pressKey(4'd4);
        checkOutput("lock.disarm_after", int'(fsm_state), 0);

        $display("[TB] async reset during alarm");
        armToArmed();
        applyStimulus(1'b0, 2'd1, 4'd0, 1'b0, 1'b0);
        idle(ENTRY_CYC + 1);
        checkOutput("async.in_alarm", int'(siren), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async.siren", int'(siren), 0);
        checkOutput("async.state", int'(fsm_state), 0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        $display("[TB] tamper in disarmed");
        applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b1);
`ifdef DOOR_ALARM_CTRL_TAMPER_EN
        checkOutput("tamper.siren", int'(siren), 1);
        checkOutput("tamper.state", int'(fsm_state), 4);
`else
        checkOutput("tamper.siren_ignored", int'(siren), 0);
        checkOutput("tamper.state_ignored", int'(fsm_state), 0);
`endif
        applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b1);
        idle(SIREN_CYC + 2);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
